neopixel_frame_driver: RTL and testbench

Parametrised WS2812B strip driver with an addressable per-LED frame buffer. It replaces the fixed two-LED, free-running-refresh arrangement. It accepts single-pixel or broadcast colour writes, for example from the CH9329 UART receiver path. It transmits a frame only when content changed or a refresh is requested, then enforces the latch/reset gap.

---
 rtl/neopixel_pkg.sv | 26 ++
 rtl/neopixel_frame_driver_bit_encoder.sv | 50 +++++
 rtl/neopixel_frame_driver.sv | 156 +++++++++++++++
 tb/tb_neopixel_frame_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the WS2812B frame driver.
// The optional brightness scaler is enabled with NEO_BRIGHTNESS_EN.
package neopixel_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_e;

    typedef enum logic {ORDER_RGB, ORDER_GRB} color_order_e;

    localparam color_order_e COLOR_ORDER = ORDER_GRB;

    // ceil(ns * freq / 1e9)
    function automatic int unsigned cycles_from_ns(longint unsigned ns, longint unsigned freq);
        return 32'((ns * freq + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

    function automatic logic [23:0] to_wire_order(logic [23:0] rgb);
        return (COLOR_ORDER == ORDER_GRB) ? {rgb[15:8], rgb[23:16], rgb[7:0]} : rgb;
    endfunction

    function automatic logic [7:0] scale_channel(logic [7:0] c, logic [7:0] level);
        logic [16:0] prod;
        prod = c * ({1'b0, level} + 9'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/neopixel_frame_driver_bit_encoder.sv
// WS2812B single-bit waveform generator: high for T0H/T1H, low for the rest of the bit.
// bit_ready rises on the final cycle of a bit so the next bit follows with no gap.
module ws2812_bit_encoder #(
    parameter int unsigned T0H_CYC = 5,
    parameter int unsigned T1H_CYC = 10,
    parameter int unsigned BIT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_valid,
    input  logic bit_val,
    output logic bit_ready,
    output logic data_out
);

    localparam int unsigned CW = $clog2(BIT_CYC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          active;
    logic          val;
    logic          last;

    assign cnt_nxt   = cnt + 1'b1;
    assign last      = (cnt == CW'(BIT_CYC - 1));
    assign bit_ready = !active || last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            val      <= 1'b0;
            data_out <= 1'b0;
        end else if (bit_valid && bit_ready) begin
            active   <= 1'b1;
            cnt      <= '0;
            val      <= bit_val;
            data_out <= 1'b1;
        end else if (active) begin
            if (last) begin
                active   <= 1'b0;
                data_out <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                data_out <= (32'(cnt_nxt) < (val ? T1H_CYC : T0H_CYC));
            end
        end
    end

endmodule

// File: rtl/neopixel_frame_driver.sv
// WS2812B strip driver with a per-LED frame buffer; sends a frame only when dirty.
// Optional brightness scaling at pixel load is enabled with NEO_BRIGHTNESS_EN.
module neopixel_frame_driver
    import neopixel_pkg::*;
#(
    parameter int unsigned SYS_FREQ = 12_090_000,
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned T0H_NS   = 400,
    parameter int unsigned T1H_NS   = 800,
    parameter int unsigned BIT_NS   = 1250,
    parameter int unsigned LATCH_US = 80
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           wr_en,
    input  logic [$clog2(NUM_LEDS > 1 ? NUM_LEDS : 2)-1:0] wr_addr,
    input  logic [23:0]                                    wr_data,
    input  logic                                           wr_all,
    input  logic                                           refresh_req,
`ifdef NEO_BRIGHTNESS_EN
    input  logic [7:0]                                     brightness,
`endif
    output logic                                           busy,
    output logic                                           frame_done,
    output logic                                           data_out
);

    localparam int unsigned AW        = $clog2(NUM_LEDS > 1 ? NUM_LEDS : 2);
    localparam int unsigned T0H_CYC   = cycles_from_ns(64'(T0H_NS), 64'(SYS_FREQ));
    localparam int unsigned T1H_CYC   = cycles_from_ns(64'(T1H_NS), 64'(SYS_FREQ));
    localparam int unsigned BIT_CYC   = cycles_from_ns(64'(BIT_NS), 64'(SYS_FREQ));
    localparam int unsigned LATCH_CYC = cycles_from_ns(64'(LATCH_US) * 64'd1000, 64'(SYS_FREQ));
    localparam int unsigned LCW       = $clog2(LATCH_CYC);

    state_e          state;
    state_e          state_nxt;
    logic [23:0]     buffer [NUM_LEDS];
    logic            dirty;
    logic [AW-1:0]   pix_idx;
    logic [4:0]      bit_cnt;
    logic [23:0]     shift;
    logic [LCW-1:0]  latch_cnt;
    logic [23:0]     pix_rgb;
    logic [23:0]     load_word;
    logic            addr_ok;
    logic            last_pix;
    logic            latch_done;
    logic            bit_valid;
    logic            bit_val;
    logic            bit_ready;
    logic            any_write;

    assign addr_ok    = (32'(wr_addr) < NUM_LEDS);
    assign last_pix   = (32'(pix_idx) == NUM_LEDS - 1);
    assign latch_done = (latch_cnt == LCW'(LATCH_CYC - 1));
    assign any_write  = wr_all || (wr_en && addr_ok);

    always_comb begin
        pix_rgb = buffer[pix_idx];
`ifdef NEO_BRIGHTNESS_EN
        pix_rgb = {scale_channel(pix_rgb[23:16], brightness),
                   scale_channel(pix_rgb[15:8],  brightness),
                   scale_channel(pix_rgb[7:0],   brightness)};
`endif
    end

    assign load_word = to_wire_order(pix_rgb);

    // The first bit of a pixel is issued straight from LOAD, so each pixel boundary costs one cycle.
    always_comb begin
        state_nxt = state;
        bit_valid = 1'b0;
        bit_val   = shift[23];
        unique case (state)
            IDLE:  if (dirty) state_nxt = LOAD;
            LOAD: begin
                bit_valid = 1'b1;
                bit_val   = load_word[23];
                state_nxt = SEND;
            end
            SEND: begin
                bit_valid = (bit_cnt != 5'd24);
                if (bit_cnt == 5'd24 && bit_ready) state_nxt = last_pix ? LATCH : LOAD;
            end
            LATCH: if (latch_done) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dirty      <= 1'b1;
            pix_idx    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            latch_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: if (dirty) begin
                    busy    <= 1'b1;
                    pix_idx <= '0;
                end
                LOAD: begin
                    shift   <= {load_word[22:0], 1'b0};
                    bit_cnt <= 5'd1;
                end
                SEND: begin
                    if (bit_valid && bit_ready) begin
                        shift   <= {shift[22:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (state_nxt == LOAD)  pix_idx   <= pix_idx + 1'b1;
                    if (state_nxt == LATCH) latch_cnt <= '0;
                end
                LATCH: begin
                    latch_cnt <= latch_cnt + 1'b1;
                    if (latch_done) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
            endcase
            // A write landing in the same cycle as frame start must survive the clear.
            if (any_write || refresh_req) dirty <= 1'b1;
            else if (state == IDLE && dirty) dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) buffer[i] <= '0;
        end else if (wr_all) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) buffer[i] <= wr_data;
        end else if (wr_en && addr_ok) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    ws2812_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_encoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .bit_ready (bit_ready),
        .data_out  (data_out)
    );

endmodule

// File: tb/tb_neopixel_frame_driver.sv
// Directed bench for neopixel_frame_driver: decodes each frame off data_out and checks timing.
// Brightness scenario is included when NEO_BRIGHTNESS_EN is defined.
module tb_neopixel_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_all, refresh_req;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        busy, frame_done, data_out;
    logic [7:0]  brightness;

    logic        s_wr_en;
    logic [2:0]  s_wr_addr;
    logic        s_busy, s_done, s_dout;

    int checks = 0;
    int errors = 0;

    logic [23:0] got   [8];
    logic [23:0] exp_w [8];

    always #5 clk = ~clk;

    neopixel_frame_driver #(.NUM_LEDS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_all      (wr_all),
        .refresh_req (refresh_req),
`ifdef NEO_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .busy        (busy),
        .frame_done  (frame_done),
        .data_out    (data_out)
    );

    neopixel_frame_driver #(.NUM_LEDS(6)) dut_six (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (s_wr_en),
        .wr_addr     (s_wr_addr),
        .wr_data     (24'hABCDEF),
        .wr_all      (1'b0),
        .refresh_req (1'b0),
`ifdef NEO_BRIGHTNESS_EN
        .brightness  (8'd255),
`endif
        .busy        (s_busy),
        .frame_done  (s_done),
        .data_out    (s_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_all(input logic [23:0] v);
        for (int i = 0; i < 8; i++) exp_w[i] = v;
    endtask

    task automatic drive_write(input logic all, input logic en, input logic [2:0] a, input logic [23:0] d);
        wr_all = all; wr_en = en; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_all = 1'b0; wr_en = 1'b0;
    endtask

    task automatic drive_refresh();
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    // Called one negedge after the trigger cycle: idle now, busy one cycle later.
    task automatic expect_start(input string tag);
        chk($sformatf("%s_pre_busy", tag), {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk($sformatf("%s_busy_rise", tag), {31'd0, busy}, 32'd1);
    endtask

    task automatic capture(input string tag, input logic next_busy);
        int unsigned h, l, guard, exp_l;
        logic ok;
        h = 0;
        for (int p = 0; p < 8; p++) begin
            ok = 1'b1;
            got[p] = '0;
            for (int b = 0; b < 24; b++) begin
                guard = 0;
                while (data_out !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
                h = 0;
                while (data_out === 1'b1 && h < 64) begin @(negedge clk); h++; end
                got[p] = {got[p][22:0], (h == 10)};
                if (h != 5 && h != 10) ok = 1'b0;
                if (!(p == 7 && b == 23)) begin
                    l = 0;
                    while (data_out !== 1'b1 && l < 64) begin @(negedge clk); l++; end
                    exp_l = 16 - h + ((b == 23) ? 1 : 0);
                    if (l != exp_l) ok = 1'b0;
                end
            end
            chk($sformatf("%s_pix%0d", tag, p), {8'd0, got[p]}, {8'd0, exp_w[p]});
            chk($sformatf("%s_pix%0d_timing", tag, p), {31'd0, ok}, 32'd1);
        end
        l = 0;
        while (frame_done !== 1'b1 && l < 2000) begin
            if (data_out !== 1'b0) ok = 1'b0;
            @(negedge clk);
            l++;
        end
        chk($sformatf("%s_latch_len", tag), l, 16 - h + 968);
        chk($sformatf("%s_latch_low", tag), {31'd0, ok}, 32'd1);
        chk($sformatf("%s_done_busy", tag), {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), {31'd0, frame_done}, 32'd0);
        chk($sformatf("%s_next_busy", tag), {31'd0, busy}, {31'd0, next_busy});
    endtask

    task automatic idle_check(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_all = 1'b0; refresh_req = 1'b0;
        wr_addr = '0; wr_data = '0; brightness = 8'd255;
        s_wr_en = 1'b0; s_wr_addr = '0;

        // Reset state, then the blanking frame
        repeat (3) @(negedge clk);
        chk("rst_data_out", {31'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_busy_rise", {31'd0, busy}, 32'd1);
        set_all(24'h000000);
        capture("boot", 1'b0);
        idle_check("boot_idle", 40);

        // Single-pixel write: red on pixel 2
        drive_write(1'b0, 1'b1, 3'd2, 24'hFF0000);
        expect_start("px2");
        set_all(24'h000000);
        exp_w[2] = 24'h00FF00;
        capture("px2", 1'b0);
        idle_check("px2_idle", 40);

        // Broadcast wins over simultaneous single write, one frame only
        drive_write(1'b1, 1'b1, 3'd0, 24'h00FF80);
        wr_data = 24'h123456;
        expect_start("bcast");
        set_all(24'hFF0080);
        capture("bcast", 1'b0);
        idle_check("bcast_idle", 60);

        // Mid-frame writes: pixel 7 during pixel 3, then pixel 0 during next frame
        drive_refresh();
        expect_start("midA");
        set_all(24'hFF0080);
        exp_w[7] = 24'h0000FF;
        fork
            capture("midA", 1'b1);
            begin
                repeat (1200) @(negedge clk);
                drive_write(1'b0, 1'b1, 3'd7, 24'h0000FF);
            end
        join
        fork
            capture("midB", 1'b1);
            begin
                repeat (1200) @(negedge clk);
                drive_write(1'b0, 1'b1, 3'd0, 24'h010203);
            end
        join
        exp_w[0] = 24'h020103;
        capture("midC", 1'b0);
        idle_check("mid_idle", 60);

        // Out-of-range address on a six-LED instance is ignored
        chk("six_idle_pre", {31'd0, s_busy}, 32'd0);
        s_wr_en = 1'b1; s_wr_addr = 3'd7;
        @(negedge clk);
        s_wr_en = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (s_busy !== 1'b0 || s_dout !== 1'b0 || s_done !== 1'b0) seen = 1'b1;
            end
            chk("six_bad_addr_no_frame", {31'd0, seen}, 32'd0);
        end

        // Refresh request resends unchanged content
        drive_refresh();
        expect_start("refresh");
        capture("refresh", 1'b0);
        idle_check("refresh_idle", 40);

        // Reset mid-frame aborts and blanks
        drive_refresh();
        expect_start("abort");
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_data_out", {31'd0, data_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_restart", {31'd0, busy}, 32'd1);
        set_all(24'h000000);
        capture("abort_blank", 1'b0);

`ifdef NEO_BRIGHTNESS_EN
        brightness = 8'd127;
        drive_write(1'b0, 1'b1, 3'd0, 24'hFF8040);
        expect_start("bright");
        set_all(24'h000000);
        exp_w[0] = 24'h407F20;
        capture("bright", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
